// File: rtl/raymarch_pkg.sv
// Shared types and constants for the raymarch frame scheduler.
package raymarch_pkg;

    // Frame scheduler states
    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        DISPATCH,
        DRAIN,
        DONE
    } sched_state_t;

    // Signed 16.16 fixed-point value as exported by the HPS PIOs
    typedef logic signed [31:0] fix16_16;

    // 3x3 lookat matrix, row-major, [31:0] = lookat_1_1
    localparam int LOOKAT_W = 9 * 32;

    // Default VGA frame geometry
    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr (wrapping).
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          grant_valid
);

    logic [PW-1:0] idx;

    // Scan requesters starting at ptr and grant the first one found
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PW'((32'(ptr) + i) % N);
            if (!grant_valid && req[idx]) begin
                grant[idx]  = 1'b1;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/raymarch_frame_scheduler.sv
// Frame-level controller: snapshots camera parameters, dispatches pixels in raster order to
// the core array round-robin, and reports frame completion once every pixel has retired.
module raymarch_frame_scheduler
    import raymarch_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int H_RES     = DEF_H_RES,
    parameter int V_RES     = DEF_V_RES,
    parameter int X_W       = 10,
    parameter int Y_W       = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  fix16_16              eye_x_in,
    input  fix16_16              eye_y_in,
    input  fix16_16              eye_z_in,
    input  logic [LOOKAT_W-1:0]  lookat_in,
    input  logic [NUM_CORES-1:0] core_ready,
    input  logic [NUM_CORES-1:0] core_retire,
    output fix16_16              eye_x,
    output fix16_16              eye_y,
    output fix16_16              eye_z,
    output logic [LOOKAT_W-1:0]  lookat,
    output logic [NUM_CORES-1:0] issue,
    output logic [X_W-1:0]       pix_x,
    output logic [Y_W-1:0]       pix_y,
    output logic                 busy,
    output logic                 frame_done,
    output logic [15:0]          frame_count,
    output logic                 overrun,
    output logic                 retire_err
);

    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int OW = $clog2(NUM_CORES + 1);
    localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

    sched_state_t         state;
    logic [X_W-1:0]       x_cnt;
    logic [Y_W-1:0]       y_cnt;
    logic [PW-1:0]        rr_ptr;
    logic [OW-1:0]        outstanding;

    logic [NUM_CORES-1:0] arb_req;
    logic [NUM_CORES-1:0] arb_grant;
    logic                 arb_valid;
    logic [PW-1:0]        grant_idx;
    logic [PW-1:0]        ptr_next;
    logic                 do_issue;
    int unsigned          retire_cnt;
    int unsigned          avail;
    logic [OW-1:0]        outstanding_next;
    logic                 retire_under;

    // A core issued last cycle is masked so it never receives back-to-back pixels
    assign arb_req  = core_ready & ~issue;
    assign do_issue = (state == DISPATCH) && arb_valid;

    rr_arbiter #(
        .N  (NUM_CORES),
        .PW (PW)
    ) u_arb (
        .req         (arb_req),
        .ptr         (rr_ptr),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    // Encode the one-hot grant and derive the pointer that follows it
    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (arb_grant[i]) grant_idx = PW'(i);
        end
        ptr_next = (int'(grant_idx) == NUM_CORES - 1) ? '0 : grant_idx + 1'b1;
    end

    // Net issue and retire traffic into the in-flight count, clamping at zero
    always_comb begin
        retire_cnt = 0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            retire_cnt = retire_cnt + 32'(core_retire[i]);
        end
        avail = 32'(outstanding) + 32'(do_issue);
        if (retire_cnt > avail) begin
            outstanding_next = '0;
            retire_under     = 1'b1;
        end else begin
            outstanding_next = OW'(avail - retire_cnt);
            retire_under     = 1'b0;
        end
    end

    // In-flight pixel counter and sticky underflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
            retire_err  <= 1'b0;
        end else if (state == LATCH) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (retire_under) retire_err <= 1'b1;
        end
    end

    // Frame FSM with registered outputs, shadow registers and raster counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            x_cnt       <= '0;
            y_cnt       <= '0;
            rr_ptr      <= '0;
            eye_x       <= '0;
            eye_y       <= '0;
            eye_z       <= '0;
            lookat      <= '0;
            issue       <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            overrun     <= 1'b0;
        end else begin
            issue      <= '0;
            frame_done <= 1'b0;
            if (frame_start && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state <= LATCH;
                        busy  <= 1'b1;
                    end
                end
                LATCH: begin
                    eye_x  <= eye_x_in;
                    eye_y  <= eye_y_in;
                    eye_z  <= eye_z_in;
                    lookat <= lookat_in;
                    x_cnt  <= '0;
                    y_cnt  <= '0;
                    state  <= DISPATCH;
                end
                DISPATCH: begin
                    if (arb_valid) begin
                        issue  <= arb_grant;
                        pix_x  <= x_cnt;
                        pix_y  <= y_cnt;
                        rr_ptr <= ptr_next;
                        if (x_cnt == X_LAST) begin
                            x_cnt <= '0;
                            if (y_cnt == Y_LAST) state <= DRAIN;
                            else                 y_cnt <= y_cnt + 1'b1;
                        end else begin
                            x_cnt <= x_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (outstanding == '0) begin
                        state       <= DONE;
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_raymarch_frame_scheduler.sv
// Directed self-checking bench for raymarch_frame_scheduler on a 4x2 frame with 4 cores.
module tb_raymarch_frame_scheduler;

    localparam int NC = 4;
    localparam int HR = 4;
    localparam int VR = 2;
    localparam int XW = 2;
    localparam int YW = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_start;
    logic [31:0]   eye_x_in, eye_y_in, eye_z_in;
    logic [287:0]  lookat_in;
    logic [NC-1:0] core_ready, core_retire;
    logic [31:0]   eye_x, eye_y, eye_z;
    logic [287:0]  lookat;
    logic [NC-1:0] issue;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          busy, frame_done, overrun, retire_err;
    logic [15:0]   frame_count;

    int n_vec = 0;
    int n_err = 0;

    // Core model controls and observation log
    logic [NC-1:0] ready_en;
    bit            hold_ready;
    bit            auto_retire;
    int            rdly;
    int            cnt [NC];
    int            cyc = 0;
    int            done_pulses = 0;
    int            iss_core[$];
    int            iss_x[$];
    int            iss_y[$];
    int            iss_cyc[$];
    logic [287:0]  lookat_pat;

    raymarch_frame_scheduler #(
        .NUM_CORES (NC),
        .H_RES     (HR),
        .V_RES     (VR),
        .X_W       (XW),
        .Y_W       (YW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .eye_x_in    (eye_x_in),
        .eye_y_in    (eye_y_in),
        .eye_z_in    (eye_z_in),
        .lookat_in   (lookat_in),
        .core_ready  (core_ready),
        .core_retire (core_retire),
        .eye_x       (eye_x),
        .eye_y       (eye_y),
        .eye_z       (eye_z),
        .lookat      (lookat),
        .issue       (issue),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .overrun     (overrun),
        .retire_err  (retire_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [287:0] got, input logic [287:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge, run the core model and log DUT activity
    task automatic step();
        int idx;
        int ones;
        @(negedge clk);
        cyc++;
        frame_start = 1'b0;
        core_retire = '0;
        if (reset) begin
            for (int i = 0; i < NC; i++) cnt[i] = 0;
        end
        for (int i = 0; i < NC; i++) begin
            if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0) core_retire[i] = 1'b1;
            end
        end
        if (issue != '0) begin
            idx  = -1;
            ones = 0;
            for (int i = 0; i < NC; i++) begin
                if (issue[i]) begin
                    idx = i;
                    ones++;
                end
            end
            if (ones != 1) idx = -1;
            iss_core.push_back(idx);
            iss_x.push_back(int'(pix_x));
            iss_y.push_back(int'(pix_y));
            iss_cyc.push_back(cyc);
            if (auto_retire && idx >= 0) cnt[idx] = rdly;
        end
        if (frame_done) done_pulses++;
        for (int i = 0; i < NC; i++) begin
            core_ready[i] = ready_en[i] && (!hold_ready || cnt[i] == 0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_issue"},   issue, 0);
        check_val({tag, "_busy"},    busy, 0);
        check_val({tag, "_pix"},     {pix_y, pix_x}, 0);
        check_val({tag, "_done"},    frame_done, 0);
        check_val({tag, "_fcount"},  frame_count, 0);
        check_val({tag, "_overrun"}, overrun, 0);
        check_val({tag, "_rerr"},    retire_err, 0);
        check_val({tag, "_eye"},     {eye_x, eye_y, eye_z}, 0);
        check_val({tag, "_lookat"},  lookat, 0);
    endtask

    // Eight issues in raster order; cores round-robin when fixed_core < 0
    task automatic check_issues(input string tag, input int base, input int fixed_core);
        int exp_core;
        check_val({tag, "_count"}, iss_core.size() - base, 8);
        for (int i = 0; i < 8; i++) begin
            if (base + i < iss_core.size()) begin
                exp_core = (fixed_core < 0) ? (i % NC) : fixed_core;
                check_val($sformatf("%s_core%0d", tag, i), iss_core[base + i], exp_core);
                check_val($sformatf("%s_x%0d", tag, i), iss_x[base + i], i % HR);
                check_val($sformatf("%s_y%0d", tag, i), iss_y[base + i], i / HR);
            end
        end
    endtask

    task automatic run_to_done(input int budget, input int d0);
        for (int k = 0; k < budget && done_pulses == d0; k++) step();
    endtask

    task automatic use_full_speed();
        ready_en    = 4'hF;
        hold_ready  = 1'b1;
        auto_retire = 1'b1;
        rdly        = 3;
    endtask

    initial begin
        int  base;
        int  d0;
        int  bad;
        bit  changed;

        reset       = 1'b1;
        frame_start = 1'b0;
        core_ready  = '0;
        core_retire = '0;
        ready_en    = '0;
        hold_ready  = 1'b1;
        auto_retire = 1'b1;
        rdly        = 3;
        for (int i = 0; i < NC; i++) cnt[i] = 0;
        for (int i = 0; i < 9; i++) lookat_pat[i*32 +: 32] = 32'h1000_0000 + 32'(i);
        eye_x_in  = 32'h0001_0000;
        eye_y_in  = 32'hFFFF_0000;
        eye_z_in  = 32'h0000_8000;
        lookat_in = lookat_pat;

        step();
        step();
        check_reset_state("rst");
        reset = 1'b0;
        step();

        // Round-robin frame with each core retiring 3 cycles after its issue
        use_full_speed();
        base        = iss_core.size();
        d0          = done_pulses;
        changed     = 1'b0;
        frame_start = 1'b1;
        for (int k = 0; k < 60 && done_pulses == d0; k++) begin
            step();
            if (!changed && iss_core.size() == base + 2) begin
                eye_x_in = 32'h0002_0000;
                changed  = 1'b1;
            end
        end
        check_val("t1_done_seen", done_pulses - d0, 1);
        repeat (4) step();
        check_val("t1_done_once", done_pulses - d0, 1);
        check_issues("t1", base, -1);
        check_val("t1_fcount", frame_count, 1);
        check_val("t1_busy_after", busy, 0);
        check_val("t2_eye_x_held", eye_x, 32'h0001_0000);
        check_val("t1_eye_y", eye_y, 32'hFFFF_0000);
        check_val("t1_eye_z", eye_z, 32'h0000_8000);
        check_val("t1_lookat", lookat, lookat_pat);
        check_val("t1_overrun", overrun, 0);
        check_val("t1_rerr", retire_err, 0);

        // Only core 2 ready; it must never be issued on consecutive cycles
        ready_en    = 4'b0100;
        hold_ready  = 1'b0;
        auto_retire = 1'b1;
        rdly        = 1;
        base        = iss_core.size();
        d0          = done_pulses;
        frame_start = 1'b1;
        run_to_done(80, d0);
        check_val("t3_done_seen", done_pulses - d0, 1);
        check_issues("t3", base, 2);
        bad = 0;
        for (int i = base + 1; i < iss_cyc.size(); i++) begin
            if (iss_cyc[i] - iss_cyc[i-1] < 2) bad++;
        end
        check_val("t3_no_b2b", bad, 0);
        check_val("t3_fcount", frame_count, 2);
        check_val("t2_eye_x_new", eye_x, 32'h0002_0000);
        step();

        // frame_start during DRAIN is flagged and otherwise ignored
        use_full_speed();
        base        = iss_core.size();
        d0          = done_pulses;
        frame_start = 1'b1;
        for (int k = 0; k < 40 && iss_core.size() < base + 8; k++) step();
        check_val("t4_overrun_pre", overrun, 0);
        frame_start = 1'b1;
        run_to_done(40, d0);
        check_val("t4_done_seen", done_pulses - d0, 1);
        check_val("t4_overrun", overrun, 1);
        check_val("t4_fcount", frame_count, 3);
        repeat (6) step();
        check_val("t4_idle", busy, 0);
        check_val("t4_no_new_issue", iss_core.size() - base, 8);
        check_val("t4_done_once", done_pulses - d0, 1);

        // Retiring two pixels with only one outstanding flags an error and clamps
        ready_en    = 4'b0001;
        hold_ready  = 1'b0;
        auto_retire = 1'b0;
        base        = iss_core.size();
        frame_start = 1'b1;
        for (int k = 0; k < 10 && iss_core.size() == base; k++) step();
        ready_en   = '0;
        core_ready = '0;
        check_val("t5_one_issue", iss_core.size() - base, 1);
        check_val("t5_outst_pre", dut.outstanding, 1);
        check_val("t5_rerr_pre", retire_err, 0);
        core_retire = 4'b0011;
        step();
        check_val("t5_rerr", retire_err, 1);
        check_val("t5_outst", dut.outstanding, 0);

        reset = 1'b1;
        step();
        step();
        check_reset_state("t5_rst");
        reset = 1'b0;
        step();

        // Reset mid-frame at pixel (2,1), then a clean restart from (0,0) and core 0
        use_full_speed();
        base        = iss_core.size();
        d0          = done_pulses;
        frame_start = 1'b1;
        for (int k = 0; k < 40 && iss_core.size() < base + 7; k++) step();
        check_val("t6_at_pixel", {iss_x[iss_core.size()-1], iss_y[iss_core.size()-1]}, {32'd2, 32'd1});
        reset = 1'b1;
        #1;
        check_reset_state("t6_async");
        step();
        step();
        reset = 1'b0;
        check_val("t6_no_done", done_pulses - d0, 0);
        repeat (3) step();
        check_val("t6_idle", busy, 0);
        base        = iss_core.size();
        d0          = done_pulses;
        frame_start = 1'b1;
        run_to_done(60, d0);
        check_val("t6_done_seen", done_pulses - d0, 1);
        check_issues("t6", base, -1);
        check_val("t6_fcount", frame_count, 1);
        check_val("t6_eye_x", eye_x, 32'h0002_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
